// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between fetch_stage (master) and imem (slave).
// One request outstanding; addr is held until valid returns.
interface fetch_stage_if;
  logic        req;
  logic [15:0] addr;
  logic [15:0] rdata;
  logic        valid;

  modport master (output req, output addr, input rdata, input valid);
  modport slave  (input req, input addr, output rdata, output valid);
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the IF/ID register, one-entry skid, drain on flush.
// Optional FETCH_PERF_CNT_EN adds fetch/bubble counters.
module fetch_stage #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] NOP_INSTR  = 16'hE000,
  parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_stall,
  input  logic                 i_flush,
  input  logic [15:0]          i_branch_pc,
  fetch_stage_if.master        imem,
  output logic [15:0]          o_curr_pc_fd,
  output logic [15:0]          o_next_pc_fd,
  output logic [15:0]          o_curr_instr_fd,
  output logic                 o_valid_fd,
  output logic                 o_halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]          o_fetch_cnt,
  output logic [15:0]          o_bubble_cnt
`endif
);

  typedef enum logic [1:0] {StRun, StDrain, StHalt} state_e;

  state_e      r_state, w_state_d;
  logic [15:0] r_pc, w_pc_d;
  logic [15:0] r_drain_addr, w_drain_addr_d;
  logic        r_skid_vld, w_skid_vld_d;
  logic [15:0] r_skid_pc, w_skid_pc_d;
  logic [15:0] r_skid_instr, w_skid_instr_d;
  logic [15:0] r_curr_pc, w_curr_pc_d;
  logic [15:0] r_next_pc, w_next_pc_d;
  logic [15:0] r_instr, w_instr_d;
  logic        r_valid_fd, w_valid_fd_d;
  logic        w_req;
  logic [15:0] w_addr;
  logic        w_resp;
  logic        w_load;

  always_comb begin
    w_req  = 1'b0;
    w_addr = r_pc;
    case (r_state)
      StRun:   w_req = ~r_skid_vld;
      StDrain: begin
        w_req  = 1'b1;
        w_addr = r_drain_addr;
      end
      default: w_req = 1'b0;
    endcase
    if (i_rst) w_req = 1'b0;
    w_resp = (r_state == StRun) && w_req && imem.valid;
  end

  always_comb begin
    w_state_d      = r_state;
    w_pc_d         = r_pc;
    w_drain_addr_d = r_drain_addr;
    w_skid_vld_d   = r_skid_vld;
    w_skid_pc_d    = r_skid_pc;
    w_skid_instr_d = r_skid_instr;
    w_curr_pc_d    = r_curr_pc;
    w_next_pc_d    = r_next_pc;
    w_instr_d      = r_instr;
    w_valid_fd_d   = r_valid_fd;
    w_load         = 1'b0;

    if (i_flush) begin
      w_curr_pc_d  = 16'h0000;
      w_next_pc_d  = 16'h0000;
      w_instr_d    = NOP_INSTR;
      w_valid_fd_d = 1'b0;
      w_skid_vld_d = 1'b0;
      w_pc_d       = i_branch_pc;
      case (r_state)
        // A pending request must be drained so its late response is not mistaken for the target.
        StRun: if (w_req && !imem.valid) begin
          w_drain_addr_d = w_addr;
          w_state_d      = StDrain;
        end
        StDrain: if (imem.valid) w_state_d = StRun;
        default: w_state_d = StRun;
      endcase
    end else begin
      case (r_state)
        StRun: begin
          if (i_stall) begin
            if (w_resp) begin
              w_skid_vld_d   = 1'b1;
              w_skid_pc_d    = r_pc;
              w_skid_instr_d = imem.rdata;
              w_pc_d         = r_pc + 16'd2;
            end
          end else if (r_skid_vld) begin
            w_load       = 1'b1;
            w_skid_vld_d = 1'b0;
            w_curr_pc_d  = r_skid_pc;
            w_next_pc_d  = r_skid_pc + 16'd2;
            w_instr_d    = r_skid_instr;
            w_valid_fd_d = 1'b1;
          end else if (w_resp) begin
            w_load       = 1'b1;
            w_curr_pc_d  = r_pc;
            w_next_pc_d  = r_pc + 16'd2;
            w_instr_d    = imem.rdata;
            w_valid_fd_d = 1'b1;
            w_pc_d       = r_pc + 16'd2;
          end
          if (w_load && (w_instr_d[15:12] == HLT_OPCODE)) w_state_d = StHalt;
        end
        StDrain: if (imem.valid) w_state_d = StRun;
        default: w_state_d = r_state;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StRun;
      r_pc         <= RESET_PC;
      r_drain_addr <= 16'h0000;
      r_skid_vld   <= 1'b0;
      r_skid_pc    <= 16'h0000;
      r_skid_instr <= 16'h0000;
      r_curr_pc    <= 16'h0000;
      r_next_pc    <= 16'h0000;
      r_instr      <= NOP_INSTR;
      r_valid_fd   <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_pc         <= w_pc_d;
      r_drain_addr <= w_drain_addr_d;
      r_skid_vld   <= w_skid_vld_d;
      r_skid_pc    <= w_skid_pc_d;
      r_skid_instr <= w_skid_instr_d;
      r_curr_pc    <= w_curr_pc_d;
      r_next_pc    <= w_next_pc_d;
      r_instr      <= w_instr_d;
      r_valid_fd   <= w_valid_fd_d;
    end
  end

  assign imem.req        = w_req;
  assign imem.addr       = w_addr;
  assign o_curr_pc_fd    = r_curr_pc;
  assign o_next_pc_fd    = r_next_pc;
  assign o_curr_instr_fd = r_instr;
  assign o_valid_fd      = r_valid_fd;
  assign o_halted        = (r_state == StHalt);

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] r_fetch_cnt, r_bubble_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fetch_cnt  <= 16'h0000;
      r_bubble_cnt <= 16'h0000;
    end else begin
      if (w_load) r_fetch_cnt <= r_fetch_cnt + 16'd1;
      if (!w_load && (r_state != StHalt)) r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end
  end

  assign o_fetch_cnt  = r_fetch_cnt;
  assign o_bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a variable-latency instruction memory model.
// Memory word at address a is 16'h1000 | a[11:0], except an optional HLT word.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] branch_pc = 16'h0000;
  logic [15:0] curr_pc_fd, next_pc_fd, curr_instr_fd;
  logic        valid_fd, halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt, bubble_cnt;
`endif

  int          lat = 0;
  int          lat_cnt;
  logic        hlt_en = 1'b0;
  logic [15:0] hlt_addr = 16'h0000;
  int          n_checks = 0;
  int          n_errors = 0;

  fetch_stage_if imem_bus ();

  fetch_stage u_dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_stall         (stall),
    .i_flush         (flush),
    .i_branch_pc     (branch_pc),
    .imem            (imem_bus),
    .o_curr_pc_fd    (curr_pc_fd),
    .o_next_pc_fd    (next_pc_fd),
    .o_curr_instr_fd (curr_instr_fd),
    .o_valid_fd      (valid_fd),
    .o_halted        (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .o_fetch_cnt     (fetch_cnt),
    .o_bubble_cnt    (bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  always_comb begin
    imem_bus.valid = imem_bus.req && (lat_cnt >= lat);
    if (hlt_en && (imem_bus.addr == hlt_addr)) imem_bus.rdata = 16'hF000;
    else imem_bus.rdata = 16'h1000 | {4'h0, imem_bus.addr[11:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) lat_cnt <= 0;
    else if (imem_bus.req && !imem_bus.valid) lat_cnt <= lat_cnt + 1;
    else lat_cnt <= 0;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_ifid(input string tag, input logic [15:0] pc, input logic [15:0] npc,
                            input logic [15:0] instr, input logic vld);
    check({tag, ".pc"}, curr_pc_fd, pc);
    check({tag, ".npc"}, next_pc_fd, npc);
    check({tag, ".instr"}, curr_instr_fd, instr);
    check({tag, ".vld"}, valid_fd, vld);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    tick();
    check("rst.req", imem_bus.req, 1'b0);
    check_ifid("rst", 16'h0000, 16'h0000, 16'hE000, 1'b0);
    check("rst.halted", halted, 1'b0);
    rst = 1'b0;

    // Zero-wait streaming
    tick(); check_ifid("t1a", 16'h0000, 16'h0002, 16'h1000, 1'b1);
    tick(); check_ifid("t1b", 16'h0002, 16'h0004, 16'h1002, 1'b1);
    tick(); check_ifid("t1c", 16'h0004, 16'h0006, 16'h1004, 1'b1);

    // Stall with skid capture
    do_reset();
    tick();
    tick();
    check("t2.pre", curr_pc_fd, 16'h0002);
    stall = 1'b1;
    tick(); check("t2.s1.pc", curr_pc_fd, 16'h0002); check("t2.s1.req", imem_bus.req, 1'b0);
    tick(); check("t2.s2.pc", curr_pc_fd, 16'h0002); check("t2.s2.req", imem_bus.req, 1'b0);
    tick(); check("t2.s3.pc", curr_pc_fd, 16'h0002);
    stall = 1'b0;
    #1 check("t2.rel.req", imem_bus.req, 1'b0);
    tick(); check_ifid("t2.skid", 16'h0004, 16'h0006, 16'h1004, 1'b1);
    #1 check("t2.req", imem_bus.req, 1'b1); check("t2.addr", imem_bus.addr, 16'h0006);
    tick(); check_ifid("t2.next", 16'h0006, 16'h0008, 16'h1006, 1'b1);

    // Flush with zero-wait response in the same cycle
    flush = 1'b1; branch_pc = 16'h0040;
    tick(); check_ifid("t3.fl", 16'h0000, 16'h0000, 16'hE000, 1'b0);
    flush = 1'b0;
    #1 check("t3.addr", imem_bus.addr, 16'h0040);
    tick(); check_ifid("t3.tgt", 16'h0040, 16'h0042, 16'h1040, 1'b1);

    // Flush during an outstanding slow request -> drain
    flush = 1'b1; branch_pc = 16'h0010;
    tick();
    flush = 1'b0; lat = 2;
    #1 check("t4.a.addr", imem_bus.addr, 16'h0010); check("t4.a.req", imem_bus.req, 1'b1);
    tick();
    flush = 1'b1; branch_pc = 16'h0040;
    #1 check("t4.b.addr", imem_bus.addr, 16'h0010);
    tick();
    flush = 1'b0;
    #1 check("t4.c.addr", imem_bus.addr, 16'h0010); check("t4.c.req", imem_bus.req, 1'b1);
    tick();
    check("t4.drop.vld", valid_fd, 1'b0); check("t4.drop.instr", curr_instr_fd, 16'hE000);
    #1 check("t4.d.addr", imem_bus.addr, 16'h0040);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (valid_fd) break;
    end
    check_ifid("t4.tgt", 16'h0040, 16'h0042, 16'h1040, 1'b1);
    lat = 0;

    // PC wrap
    flush = 1'b1; branch_pc = 16'hFFFE;
    tick();
    flush = 1'b0;
    tick(); check_ifid("wrap.a", 16'hFFFE, 16'h0000, 16'h1FFE, 1'b1);
    tick(); check_ifid("wrap.b", 16'h0000, 16'h0002, 16'h1000, 1'b1);

    // Reset while a request is waiting
    lat = 2;
    flush = 1'b1; branch_pc = 16'h0100;
    tick();
    flush = 1'b0;
    tick();
    rst = 1'b1;
    #1 check("rmw.req", imem_bus.req, 1'b0);
    tick(); check("rmw.vld", valid_fd, 1'b0); check("rmw.instr", curr_instr_fd, 16'hE000);
    rst = 1'b0; lat = 0;

    // HLT capture, then flush out of HALT
    hlt_en = 1'b1; hlt_addr = 16'h0008;
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    check("t5.halted", halted, 1'b1);
    check("t5.pc", curr_pc_fd, 16'h0008);
    check("t5.instr", curr_instr_fd, 16'hF000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5.req", imem_bus.req, 1'b0);
    end
    check("t5.hold.pc", curr_pc_fd, 16'h0008);
    flush = 1'b1; branch_pc = 16'h0020;
    tick(); check("t5.unhalt", halted, 1'b0); check("t5.unhalt.instr", curr_instr_fd, 16'hE000);
    flush = 1'b0;
    tick(); check_ifid("t5.resume", 16'h0020, 16'h0022, 16'h1020, 1'b1);

    // Flush in the same edge as the HLT response
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    check("t5b.pre", curr_pc_fd, 16'h0006);
    flush = 1'b1; branch_pc = 16'h0040;
    tick(); check("t5b.halted", halted, 1'b0); check("t5b.instr", curr_instr_fd, 16'hE000);
    flush = 1'b0;
    tick(); check_ifid("t5b.tgt", 16'h0040, 16'h0042, 16'h1040, 1'b1);
    check("t5b.halted2", halted, 1'b0);
    hlt_en = 1'b0;

`ifdef FETCH_PERF_CNT_EN
    // Perf counters: 10 fetches and 3 stall cycles
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    stall = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("t6.fetch", fetch_cnt, 16'd10);
    check("t6.bubble", bubble_cnt, 16'd3);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
